shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Command sequencer for an N-bit universal shift register (hold/shl/shr/load via 2-bit ctrl).
//  Accepts one command at a time over a valid/ready port and drives the register's ctrl/d inputs:
//  - a one-cycle parallel load, or
//  - a counted run of single-bit shifts with a serial fill bit.
//  Returns the resulting register value on a valid/ready response port.
//  Sits between a host/CSR master and the shift-register datapath.
// PARAMETERS
//  N   8                 register width, N >= 2
//  CW  $clog2(N+1)       width of shift-count field
// PORTS
//  clk        in   1     single clock, all logic rising-edge
//  reset_n    in   1     asynchronous, active-low reset
//  cmd_valid  in   1     command present
//  cmd_ready  out  1     controller can accept command (IDLE only)
//  cmd_op     in   2     00 READ, 01 SHL, 10 SHR, 11 LOAD
//  cmd_data   in   N     parallel load value (LOAD only)
//  cmd_cnt    in   CW    shift count (SHL/SHR only)
//  cmd_fill   in   1     serial bit inserted on every shift
//  sr_ctrl    out  2     to shift register: 00 hold, 01 left, 10 right, 11 load
//  sr_d       out  N     to shift register d input
//  sr_q       in   N     shift register q output
//  rsp_valid  out  1     result available
//  rsp_ready  in   1     result consumer ready
//  rsp_data   out  N     result, = sr_q; qualified by rsp_valid
// BEHAVIOUR
//  Reset (reset_n low, async):
//  - state=IDLE, shift counter=0, captured command=0.
//  - Outputs: sr_ctrl=00, sr_d=0, rsp_valid=0, cmd_ready=1.
//  - Reset mid-operation aborts the command at once: sr_ctrl=00, no response is issued.
//  FSM states: IDLE, LOAD, SHIFT, RESP. sr_ctrl and sr_d are decoded from registered state only.
//  - IDLE
//    - Outputs: cmd_ready=1, sr_ctrl=00, sr_d=0.
//    - On cmd_valid&cmd_ready, capture op/data/cnt/fill.
//    - Next state: READ -> RESP; LOAD -> LOAD; SHL/SHR with cnt=0 -> RESP; SHL/SHR with cnt>0 -> SHIFT.
//    - cnt is loaded into the counter clamped to N (any cnt > N behaves as N).
//  - LOAD
//    - Exactly one cycle: sr_ctrl=11, sr_d=cmd_data. Next state: RESP.
//  - SHIFT
//    - SHL: sr_ctrl=01, sr_d[0]=fill, other sr_d bits 0.
//    - SHR: sr_ctrl=10, sr_d[N-1]=fill, other sr_d bits 0.
//    - Counter decrements each cycle. On the cycle the counter is 1, next state is RESP.
//    - Exactly min(cnt,N) shift cycles are issued.
//  - RESP
//    - sr_ctrl=00 (register holds), rsp_valid=1, rsp_data=sr_q.
//    - rsp_valid and rsp_data stay stable until rsp_ready. On rsp_valid&rsp_ready -> IDLE.
//  Latency, with the command accepted at edge k:
//  - READ: rsp_valid high from cycle k+1.
//  - LOAD: rsp_valid high from cycle k+2.
//  - SHL/SHR cnt=c>0: rsp_valid high from cycle k+min(c,N)+1.
//  Handshake rules:
//  - One command outstanding. cmd_ready=0 in LOAD, SHIFT and RESP.
//  - cmd_valid while not ready is ignored; nothing is queued.
//  - Response accepted at edge j -> cmd_ready=1 in cycle j+1. No same-cycle accept of the next command.
//  - rsp_ready held high with no response pending has no effect.
//  The shift register is never driven with ctrl!=00 outside LOAD/SHIFT. Its value persists across commands.
// TESTING (N=8)
//  1. Assert reset_n=0 mid-SHIFT (cnt=5, after 2 shifts):
//     - sr_ctrl=00, rsp_valid=0, cmd_ready=1 immediately.
//     - After release, READ returns the register's own reset value 0x00.
//  2. LOAD 0xA5, then READ:
//     - sr_ctrl=11 and sr_d=0xA5 for exactly one cycle; rsp_data=0xA5 at k+2.
//     - READ response 0xA5 at k+1.
//  3. LOAD 0x81, SHL cnt=3 fill=1:
//     - Three cycles of sr_ctrl=01; rsp_data=0x0F at k+4.
//     - Then SHR cnt=2 fill=0 -> rsp_data=0x03.
//  4. SHR cnt=0, and separately SHL cnt=15 after LOAD 0xFF with fill=0:
//     - cnt=0: no shift cycles, response at k+1.
//     - cnt=15: exactly 8 shift cycles, rsp_data=0x00.
//  5. Hold rsp_ready=0 for 4 cycles in RESP while toggling cmd_valid:
//     - rsp_valid/rsp_data stable; sr_ctrl=00; cmd_ready=0; no command captured.
//     - After accept, cmd_ready=1 next cycle.
//  6. Back-to-back LOAD/SHL/READ with cmd_valid and rsp_ready held high:
//     - Every response arrives at its stated latency.
//     - Exactly one IDLE cycle between commands.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Host-side command/response port of the shift-register sequencer.
// The master drives commands and accepts responses; the slave is the controller.
interface shift_seq_ctrl_if #(
    parameter int N = 8
) ();
    localparam int CW = $clog2(N + 1);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [N-1:0]  cmd_data;
    logic [CW-1:0] cmd_cnt;
    logic          cmd_fill;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an N-bit universal shift register: one-cycle loads,
// counted single-bit shifts with a serial fill bit, and a held result response.
module shift_seq_ctrl #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    shift_seq_ctrl_if.slave  bus,
    output logic [1:0]       sr_ctrl,
    output logic [N-1:0]     sr_d,
    input  logic [N-1:0]     sr_q
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_LEFT  = 2'b01;
    localparam logic [1:0] SR_RIGHT = 2'b10;
    localparam logic [1:0] SR_LOAD  = 2'b11;

    state_t        state, state_nxt;
    op_t           op_q;
    logic [N-1:0]  data_q;
    logic          fill_q;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          accept;
    logic [CW-1:0] cnt_clamped;

    // Ready is exactly "in IDLE", so accept does not need to read back cmd_ready.
    assign accept      = (state == IDLE) && bus.cmd_valid;
    assign cnt_clamped = (bus.cmd_cnt > CW'(N)) ? CW'(N) : bus.cmd_cnt;
    assign bus.rsp_data = sr_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt_q  <= '0;
            op_q   <= OP_READ;
            data_q <= '0;
            fill_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            if (accept) begin
                op_q   <= op_t'(bus.cmd_op);
                data_q <= bus.cmd_data;
                fill_q <= bus.cmd_fill;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_q;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        sr_ctrl       = SR_HOLD;
        sr_d          = '0;

        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    unique case (op_t'(bus.cmd_op))
                        OP_READ: state_nxt = RESP;
                        OP_LOAD: state_nxt = LOAD;
                        default: begin
                            cnt_nxt   = cnt_clamped;
                            state_nxt = (cnt_clamped == '0) ? RESP : SHIFT;
                        end
                    endcase
                end
            end

            LOAD: begin
                sr_ctrl   = SR_LOAD;
                sr_d      = data_q;
                state_nxt = RESP;
            end

            SHIFT: begin
                if (op_q == OP_SHL) begin
                    sr_ctrl = SR_LEFT;
                    sr_d[0] = fill_q;
                end else begin
                    sr_ctrl   = SR_RIGHT;
                    sr_d[N-1] = fill_q;
                end
                cnt_nxt = cnt_q - CW'(1);
                // The counter still holds 1 during the final shift cycle.
                if (cnt_q == CW'(1)) begin
                    state_nxt = RESP;
                end
            end

            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl with a behavioural universal shift register.
module tb_shift_seq_ctrl;
    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   sr_ctrl;
    logic [N-1:0] sr_d;
    logic [N-1:0] sr_q;

    shift_seq_ctrl_if #(.N(N)) bus ();

    shift_seq_ctrl #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .sr_ctrl (sr_ctrl),
        .sr_d    (sr_d),
        .sr_q    (sr_q)
    );

    always #5 clk = ~clk;

    // Datapath: universal shift register resetting to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            case (sr_ctrl)
                2'b01:   sr_q <= {sr_q[N-2:0], sr_d[0]};
                2'b10:   sr_q <= {sr_d[N-1], sr_q[N-1:1]};
                2'b11:   sr_q <= sr_d;
                default: sr_q <= sr_q;
            endcase
        end
    end

    typedef struct {
        logic [N-1:0] data;
        int           lat;
        logic [1:0]   ctrl;
        logic [N-1:0] d;
        int           active;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] model_reg;
    int           checks = 0;
    int           errors = 0;

    // Present a command, push its expected outcome, return at the negedge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [N-1:0] data,
                         input int cnt, input logic fill, input bit hold);
        exp_t e;
        int   c;
        int   w;
        c = (cnt > N) ? N : cnt;
        e.data = '0; e.lat = 1; e.ctrl = 2'b00; e.d = '0; e.active = 0;
        case (op)
            OP_SHL: begin
                for (int i = 0; i < c; i++) model_reg = {model_reg[N-2:0], fill};
                e.lat = c + 1; e.ctrl = 2'b01; e.d = {{(N-1){1'b0}}, fill}; e.active = c;
            end
            OP_SHR: begin
                for (int i = 0; i < c; i++) model_reg = {fill, model_reg[N-1:1]};
                e.lat = c + 1; e.ctrl = 2'b10; e.d = {fill, {(N-1){1'b0}}}; e.active = c;
            end
            OP_LOAD: begin
                model_reg = data;
                e.lat = 2; e.ctrl = 2'b11; e.d = data; e.active = 1;
            end
            default: ;
        endcase
        e.data = model_reg;
        sb.push_back(e);

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_cnt   = CW'(cnt);
        bus.cmd_fill  = fill;
        w = 0;
        while (!bus.cmd_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
        end
        @(negedge clk);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    // Pop the oldest expectation and compare the datapath drive, latency and result.
    task automatic wait_rsp(input int stall);
        exp_t         e;
        int           n;
        int           act;
        logic [N-1:0] held;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        bus.rsp_ready = (stall == 0);
        n = 1;
        act = 0;
        while (!bus.rsp_valid && n <= 40) begin
            if (sr_ctrl !== 2'b00) begin
                act++;
                checks++;
                if (sr_ctrl !== e.ctrl || sr_d !== e.d) begin
                    errors++;
                    $display("FAIL sr_drive: ctrl=%b d=%h required ctrl=%b d=%h",
                             sr_ctrl, sr_d, e.ctrl, e.d);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== e.lat) begin
            errors++;
            $display("FAIL rsp_latency: got %0d required %0d", n, e.lat);
        end
        checks++;
        if (act !== e.active) begin
            errors++;
            $display("FAIL active_cycles: got %0d required %0d", act, e.active);
        end
        checks++;
        if (bus.rsp_data !== e.data) begin
            errors++;
            $display("FAIL rsp_data: got %h required %h", bus.rsp_data, e.data);
        end
        checks++;
        if (sr_ctrl !== 2'b00 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL resp_state: sr_ctrl=%b cmd_ready=%b required 00/0",
                     sr_ctrl, bus.cmd_ready);
        end
        held = bus.rsp_data;
        for (int i = 0; i < stall; i++) begin
            bus.cmd_valid = ~bus.cmd_valid;
            bus.cmd_op    = OP_LOAD;
            bus.cmd_data  = 8'h55;
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held ||
                sr_ctrl !== 2'b00 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h ctrl=%b ready=%b required 1/%h/00/0",
                         bus.rsp_valid, bus.rsp_data, sr_ctrl, bus.cmd_ready, held);
            end
        end
        if (stall > 0) begin
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_accept: cmd_ready=%b rsp_valid=%b required 1/0",
                     bus.cmd_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_READ;
        bus.cmd_data  = '0;
        bus.cmd_cnt   = '0;
        bus.cmd_fill  = 1'b0;
        bus.rsp_ready = 1'b0;
        reset_n       = 1'b0;
        model_reg     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (sr_ctrl !== 2'b00 || sr_d !== '0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: ctrl=%b d=%h rsp_valid=%b cmd_ready=%b required 00/00/0/1",
                     sr_ctrl, sr_d, bus.rsp_valid, bus.cmd_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_read();
        issue(OP_LOAD, 8'hA5, 0, 1'b0, 1'b0);
        wait_rsp(0);
        issue(OP_READ, 8'h00, 0, 1'b0, 1'b0);
        wait_rsp(0);
    endtask

    task automatic test_shift();
        issue(OP_LOAD, 8'h81, 0, 1'b0, 1'b0);
        wait_rsp(0);
        issue(OP_SHL, 8'h00, 3, 1'b1, 1'b0);
        wait_rsp(0);
        issue(OP_SHR, 8'h00, 2, 1'b0, 1'b0);
        wait_rsp(0);
        issue(OP_SHR, 8'h00, 3, 1'b1, 1'b0);
        wait_rsp(0);
    endtask

    task automatic test_count_bounds();
        issue(OP_SHR, 8'h00, 0, 1'b1, 1'b0);
        wait_rsp(0);
        issue(OP_LOAD, 8'hFF, 0, 1'b0, 1'b0);
        wait_rsp(0);
        issue(OP_SHL, 8'h00, 15, 1'b0, 1'b0);
        wait_rsp(0);
        issue(OP_SHR, 8'h00, 8, 1'b1, 1'b0);
        wait_rsp(0);
    endtask

    task automatic test_rsp_stall();
        issue(OP_LOAD, 8'h3C, 0, 1'b0, 1'b0);
        wait_rsp(0);
        issue(OP_READ, 8'h00, 0, 1'b0, 1'b0);
        wait_rsp(4);
        issue(OP_READ, 8'h00, 0, 1'b0, 1'b0);
        wait_rsp(0);
    endtask

    task automatic test_back_to_back();
        issue(OP_LOAD, 8'h3C, 0, 1'b0, 1'b1);
        wait_rsp(0);
        issue(OP_SHL, 8'h00, 2, 1'b1, 1'b1);
        wait_rsp(0);
        issue(OP_READ, 8'h00, 0, 1'b0, 1'b1);
        wait_rsp(0);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        exp_t dropped;
        issue(OP_LOAD, 8'h3C, 0, 1'b0, 1'b0);
        wait_rsp(0);
        issue(OP_SHL, 8'h00, 5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (sr_ctrl !== 2'b01) begin
            errors++;
            $display("FAIL mid_shift: sr_ctrl=%b required 01", sr_ctrl);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (sr_ctrl !== 2'b00 || sr_d !== '0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: ctrl=%b d=%h rsp_valid=%b cmd_ready=%b required 00/00/0/1",
                     sr_ctrl, sr_d, bus.rsp_valid, bus.cmd_ready);
        end
        dropped = sb.pop_back();
        model_reg = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_rsp: rsp_valid=%b required 0", bus.rsp_valid);
        end
        reset_n = 1'b1;
        @(negedge clk);
        issue(OP_READ, 8'h00, 0, 1'b0, 1'b0);
        wait_rsp(0);
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_shift();
        test_count_bounds();
        test_rsp_stall();
        test_back_to_back();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
